// File: rtl/fibre_a_spike_mem_if.sv
`default_nettype none
// ============================================================================
// fibre_a_spike_mem_if : fibre_a spike-read request/response bundle
// Revision 1.0
// ============================================================================
interface fibre_a_spike_mem_if #(
   parameter int TIMESTEPS  = 4,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] fibre_a_addr;
   logic                  fibre_a_read_en;
   logic [TIMESTEPS-1:0]  fibre_a_data;
   logic                  fibre_a_valid;
   logic                  fibre_a_miss;

   modport master (
      output fibre_a_addr, fibre_a_read_en,
      input  fibre_a_data, fibre_a_valid, fibre_a_miss
   );

   modport slave (
      input  fibre_a_addr, fibre_a_read_en,
      output fibre_a_data, fibre_a_valid, fibre_a_miss
   );
endinterface
`default_nettype wire

// File: rtl/fibre_a_spike_mem.sv
`default_nettype none
// ============================================================================
// fibre_a_spike_mem : spike-word store answering fibre_a reads after READ_LATENCY
// Optional macro FIBRE_A_SPIKE_MEM_BYPASS_EN : same-cycle write-to-read bypass
// Revision 1.0
// ============================================================================
module fibre_a_spike_mem #(
   parameter int TIMESTEPS    = 4,
   parameter int ADDR_WIDTH   = 8,
   parameter int READ_LATENCY = 2
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  load_start,
   input  wire logic                  load_done,
   input  wire logic                  wr_en,
   input  wire logic [ADDR_WIDTH-1:0] wr_addr,
   input  wire logic [TIMESTEPS-1:0]  wr_data,
   fibre_a_spike_mem_if.slave         rd,
   output      logic                  mem_ready
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [1:0] S_EMPTY   = 2'd0;
   localparam logic [1:0] S_LOADING = 2'd1;
   localparam logic [1:0] S_READY   = 2'd2;

   logic [1:0]              r_state;
   logic [1:0]              w_state_nxt;
   logic                    r_ready;
   logic [TIMESTEPS-1:0]    r_mem [DEPTH];
   logic [DEPTH-1:0]        r_written;

   logic                    w_wr_accept;
   logic                    w_is_ready;
   logic                    w_bypass;
   logic                    w_rd_hit;
   logic [TIMESTEPS-1:0]    w_rd_data;

   logic [READ_LATENCY-1:0] r_pv;
   logic [READ_LATENCY-1:0] r_pm;
   logic [TIMESTEPS-1:0]    r_pd [READ_LATENCY];

   // load_start drops any write in the same cycle
   assign w_wr_accept = wr_en && !load_start && (r_state != S_EMPTY);
   assign w_is_ready  = (r_state == S_READY);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY:   if (load_start) w_state_nxt = S_LOADING;
         S_LOADING: if (!load_start && load_done) w_state_nxt = S_READY;
         S_READY:   if (load_start) w_state_nxt = S_LOADING;
         default:   w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_EMPTY;
         r_ready   <= 1'b0;
         r_written <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == S_READY);
         if (load_start)
            r_written <= '0;
         else if (w_wr_accept)
            r_written[wr_addr] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_accept)
         r_mem[wr_addr] <= wr_data;
   end

`ifdef FIBRE_A_SPIKE_MEM_BYPASS_EN
   assign w_bypass = w_wr_accept && (wr_addr == rd.fibre_a_addr) && w_is_ready;
`else
   assign w_bypass = 1'b0;
`endif

   // result is resolved at issue so later loads/writes cannot disturb it
   assign w_rd_hit  = w_bypass || (w_is_ready && r_written[rd.fibre_a_addr]);
   assign w_rd_data = w_bypass ? wr_data :
                      (w_rd_hit ? r_mem[rd.fibre_a_addr] : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pv <= '0;
         r_pm <= '0;
         for (int k = 0; k < READ_LATENCY; k++)
            r_pd[k] <= '0;
      end else begin
         r_pv[0] <= rd.fibre_a_read_en;
         if (rd.fibre_a_read_en) begin
            r_pd[0] <= w_rd_data;
            r_pm[0] <= !w_rd_hit;
         end
         // payload only advances with a valid so the outputs hold between pulses
         for (int k = 1; k < READ_LATENCY; k++) begin
            r_pv[k] <= r_pv[k-1];
            if (r_pv[k-1]) begin
               r_pd[k] <= r_pd[k-1];
               r_pm[k] <= r_pm[k-1];
            end
         end
      end
   end

   assign rd.fibre_a_valid = r_pv[READ_LATENCY-1];
   assign rd.fibre_a_data  = r_pd[READ_LATENCY-1];
   assign rd.fibre_a_miss  = r_pm[READ_LATENCY-1];
   assign mem_ready        = r_ready;

endmodule
`default_nettype wire
